// File: rtl/tail_input_cond.sv
// Input conditioner for the tail-light FSM: 2-flop sync, per-channel debounce,
// left/right/hazard priority resolution and a tick divider (built when TAILCOND_TICK_EN is defined).
module tail_input_cond #(
   parameter int DEB_CYCLES = 4,
   parameter int TICK_DIV   = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_left,
   input  logic raw_right,
   input  logic raw_hazard,
   output logic left,
   output logic right,
   output logic hazards,
   output logic tick
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   // Channel index: 0 = left, 1 = right, 2 = hazard.
   logic [2:0]    raw;
   logic [2:0]    s1;
   logic [2:0]    s2;
   logic [2:0]    st;
   logic [CW-1:0] cnt [3];

   assign raw = {raw_hazard, raw_right, raw_left};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Any disagreement between s2 and st restarts from zero on a bounce;
   // only DEB_CYCLES consecutive disagreeing samples move st.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st <= '0;
         for (int i = 0; i < 3; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (s2[i] == st[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               st[i]  <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   assign hazards = st[2] | (st[0] & st[1]);
   assign left    = st[0] & ~st[1] & ~st[2];
   assign right   = st[1] & ~st[0] & ~st[2];

`ifdef TAILCOND_TICK_EN
   localparam int DW = $clog2(TICK_DIV);
   localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

   logic [DW-1:0] div;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div  <= '0;
         tick <= 1'b0;
      end else if (div == DIV_MAX) begin
         div  <= '0;
         tick <= 1'b1;
      end else begin
         div  <= div + DW'(1);
         tick <= 1'b0;
      end
   end
`else
   // Fast simulation mode: the FSM steps every clock; TICK_DIV has no effect.
   assign tick = 1'b1 | (TICK_DIV < 2);
`endif

endmodule
